// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcode/state enums and instruction field positions for the accumulator CPU.
package cpu_pkg;
    localparam int INSTR_W  = 9;
    localparam int OPC_W    = 5;
    localparam int OPND_W   = 4;
    localparam int OPC_LSB  = 4;
    localparam int OPND_LSB = 0;
    typedef enum logic [4:0] {
        OP_ADD = 0, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR,
        OP_LDI, OP_LD, OP_ST, OP_INC, OP_DEC, OP_NEG, OP_ADDI, OP_SUBI,
        OP_MOV, OP_LOADM, OP_CMP, OP_STOREM, OP_NOP, OP_SLT,
        OP_BEQ = 22, OP_RB = 23, OP_AB = 24, OP_DONE = 31
    } opcode_t;
    typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM_WAIT, HALT} state_t;
endpackage

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: multi-cycle fetch/decode/branch sequencer for the accumulator CPU.
// Optional FETCH_CTRL_CYCLE_CNT_EN adds a saturating busy-cycle counter output.
module fetch_ctrl #(
    parameter int PC_W    = 10,
    parameter int INSTR_W = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [PC_W-1:0]    instr_addr,
    input  logic [INSTR_W-1:0] instr_rdata,
    input  logic [7:0]         acc_in,
    input  logic [7:0]         val_in,
    output logic [4:0]         opcode,
    output logic [3:0]         operand,
    output logic               instr_valid,
    output logic               mem_req,
    input  logic               mem_ack,
    output logic               done
`ifdef FETCH_CTRL_CYCLE_CNT_EN
    ,
    output logic [15:0]        cycle_count
`endif
);
    import cpu_pkg::*;

    state_t state, state_nx;
    logic [PC_W-1:0] pc, pc_nx, pc_inc;
    logic cond_flag, cond_nx;
    logic [INSTR_W-1:0] instr_q;
    logic [4:0] op_x;
    logic mem_op;

    assign op_x       = instr_rdata[OPC_LSB +: OPC_W];
    assign mem_op     = (op_x == OP_LOADM) || (op_x == OP_STOREM);
    assign pc_inc     = pc + PC_W'(1);
    assign instr_addr = pc;
    assign done       = (state == HALT);

    always_comb begin
        state_nx    = state;
        pc_nx       = pc;
        cond_nx     = cond_flag;
        opcode      = '0;
        operand     = '0;
        instr_valid = 1'b0;
        mem_req     = 1'b0;
        case (state)
            IDLE, HALT: if (start) begin
                pc_nx    = '0;
                cond_nx  = 1'b0;
                state_nx = FETCH;
            end
            FETCH: state_nx = EXEC;
            EXEC: begin
                opcode      = op_x;
                operand     = instr_rdata[OPND_LSB +: OPND_W];
                instr_valid = !mem_op;
                mem_req     = mem_op;
                state_nx    = mem_op ? MEM_WAIT : (op_x == OP_DONE) ? HALT : FETCH;
                // memory ops advance pc on ack; halt keeps pc on the done instruction
                if (!mem_op && op_x != OP_DONE)
                    pc_nx = (op_x == OP_RB && cond_flag) ? pc + {{(PC_W-8){val_in[7]}}, val_in} :
                            (op_x == OP_AB && cond_flag) ? PC_W'(val_in) : pc_inc;
                if (op_x == OP_BEQ)
                    cond_nx = (acc_in == val_in);
                else if (op_x == OP_RB || op_x == OP_AB)
                    cond_nx = 1'b0;
            end
            MEM_WAIT: begin
                opcode  = instr_q[OPC_LSB +: OPC_W];
                operand = instr_q[OPND_LSB +: OPND_W];
                mem_req = 1'b1;
                if (mem_ack) begin
                    instr_valid = 1'b1;
                    pc_nx       = pc_inc;
                    state_nx    = FETCH;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pc        <= '0;
            cond_flag <= 1'b0;
            instr_q   <= '0;
        end else begin
            state     <= state_nx;
            pc        <= pc_nx;
            cond_flag <= cond_nx;
            if (state == EXEC)
                instr_q <= instr_rdata;
        end
    end

`ifdef FETCH_CTRL_CYCLE_CNT_EN
    always_ff @(posedge clk) begin
        if (reset || ((state == IDLE || state == HALT) && start))
            cycle_count <= '0;
        else if (state inside {FETCH, EXEC, MEM_WAIT} && cycle_count != 16'hFFFF)
            cycle_count <= cycle_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed table-driven and sequence checks for fetch_ctrl.
module tb_fetch_ctrl;
    import cpu_pkg::*;

    logic       clk = 1'b0;
    logic       reset, start, mem_ack;
    logic [9:0] instr_addr;
    logic [8:0] instr_rdata;
    logic [7:0] acc_in, val_in;
    logic [4:0] opcode;
    logic [3:0] operand;
    logic       instr_valid, mem_req, done;
`ifdef FETCH_CTRL_CYCLE_CNT_EN
    logic [15:0] cycle_count;
`endif

    logic [8:0] rom [1024];
    int errors = 0;
    int checks = 0;

    fetch_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .instr_addr(instr_addr),
        .instr_rdata(instr_rdata), .acc_in(acc_in), .val_in(val_in),
        .opcode(opcode), .operand(operand), .instr_valid(instr_valid),
        .mem_req(mem_req), .mem_ack(mem_ack), .done(done)
`ifdef FETCH_CTRL_CYCLE_CNT_EN
        , .cycle_count(cycle_count)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) instr_rdata <= rom[instr_addr];

    typedef struct {
        logic [9:0] addr;
        logic [8:0] instr;
        logic [7:0] acc;
        logic [7:0] val;
        logic [9:0] nxt;
    } vec_t;
    vec_t v [14];

    function automatic logic [8:0] ins(input logic [4:0] op, input logic [3:0] r);
        return {op, r};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 1024; i++) rom[i] = '0;
    endtask

    task automatic start_prog();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_active(input bit want_mem, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (want_mem ? mem_req : (instr_valid || mem_req)) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        bit ok;
        int nreq;
        reset = 1'b1; start = 1'b0; mem_ack = 1'b0; acc_in = '0; val_in = '0;
        clear_rom();
        repeat (2) @(negedge clk);
        chk("rst_valid", instr_valid, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", instr_addr, 0);
        chk("rst_opcode", opcode, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_addr", instr_addr, 0);
        chk("idle_valid", instr_valid, 0);

        // three-instruction program: commits on cycles 2,4,6, halt from 7
        rom[0] = ins(OP_ADD, 1); rom[1] = ins(OP_ADD, 2); rom[2] = ins(OP_DONE, 0);
        start_prog();
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) @(negedge clk);
            chk($sformatf("p3_valid_c%0d", k), instr_valid, (k == 2 || k == 4 || k == 6));
            if (k == 2 || k == 4 || k == 6)
                chk($sformatf("p3_addr_c%0d", k), instr_addr, (k - 2) / 2);
            chk($sformatf("p3_done_c%0d", k), done, (k >= 7));
        end
`ifdef FETCH_CTRL_CYCLE_CNT_EN
        chk("p3_cycle_count", cycle_count, 6);
`endif

        // branch / wrap chain, restarted from HALT
        v[0]  = '{10'd0,    ins(OP_ADD, 1),  8'd0, 8'd0,    10'd1};
        v[1]  = '{10'd1,    ins(OP_SUB, 2),  8'd0, 8'd0,    10'd2};
        v[2]  = '{10'd2,    ins(OP_BEQ, 3),  8'd5, 8'd5,    10'd3};
        v[3]  = '{10'd3,    ins(OP_OR, 4),   8'd0, 8'd0,    10'd4};
        v[4]  = '{10'd4,    ins(OP_AB, 5),   8'd0, 8'd9,    10'd9};
        v[5]  = '{10'd9,    ins(OP_BEQ, 6),  8'd5, 8'd5,    10'd10};
        v[6]  = '{10'd10,   ins(OP_RB, 7),   8'd0, 8'hFE,   10'd8};
        v[7]  = '{10'd8,    ins(OP_ADD, 0),  8'd0, 8'd0,    10'd9};
        v[8]  = '{10'd9,    ins(OP_BEQ, 6),  8'd5, 8'd4,    10'd10};
        v[9]  = '{10'd10,   ins(OP_RB, 7),   8'd0, 8'hFE,   10'd11};
        v[10] = '{10'd11,   ins(OP_AB, 8),   8'd0, 8'd40,   10'd12};
        v[11] = '{10'd12,   ins(OP_BEQ, 9),  8'd1, 8'd1,    10'd13};
        v[12] = '{10'd13,   ins(OP_RB, 10),  8'd0, 8'hF2,   10'd1023};
        v[13] = '{10'd1023, ins(OP_ADD, 15), 8'd0, 8'd0,    10'd0};
        clear_rom();
        foreach (v[i]) rom[v[i].addr] = v[i].instr;
        start_prog();
        foreach (v[i]) begin
            acc_in = v[i].acc;
            val_in = v[i].val;
            wait_active(1'b0, ok);
            chk($sformatf("v%0d_reached", i), ok, 1);
            chk($sformatf("v%0d_addr", i), instr_addr, v[i].addr);
            chk($sformatf("v%0d_opcode", i), opcode, v[i].instr[8:4]);
            chk($sformatf("v%0d_operand", i), operand, v[i].instr[3:0]);
            chk($sformatf("v%0d_valid", i), instr_valid, 1);
            @(negedge clk);
            chk($sformatf("v%0d_next", i), instr_addr, v[i].nxt);
            chk($sformatf("v%0d_fetch_quiet", i), instr_valid, 0);
        end

        // loadm at pc=3 with ack on the third mem_req cycle
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        clear_rom();
        rom[3] = ins(OP_LOADM, 5); rom[4] = ins(OP_DONE, 0);
        start_prog();
        wait_active(1'b1, ok);
        chk("ld_seen", ok, 1);
        chk("ld_addr", instr_addr, 3);
        chk("ld_exec_valid", instr_valid, 0);
        chk("ld_exec_opcode", opcode, OP_LOADM);
        nreq = 1;
        @(negedge clk);
        nreq += int'(mem_req);
        chk("ld_wait_valid", instr_valid, 0);
        chk("ld_wait_operand", operand, 5);
        @(negedge clk);
        nreq += int'(mem_req);
        mem_ack = 1'b1;
        #1;
        chk("ld_ack_valid", instr_valid, 1);
        chk("ld_ack_opcode", opcode, OP_LOADM);
        @(negedge clk) mem_ack = 1'b0;
        chk("ld_req_drop", mem_req, 0);
        chk("ld_req_cycles", nreq, 3);
        chk("ld_next_addr", instr_addr, 4);
        repeat (2) @(negedge clk);
        chk("ld_halt_done", done, 1);

        // reset beats start and mem_ack during MEM_WAIT
        start_prog();
        wait_active(1'b1, ok);
        chk("rmw_seen", ok, 1);
        @(negedge clk);
        chk("rmw_in_wait", mem_req, 1);
        reset = 1'b1; mem_ack = 1'b1; start = 1'b1;
        @(negedge clk);
        chk("rmw_req", mem_req, 0);
        chk("rmw_done", done, 0);
        chk("rmw_addr", instr_addr, 0);
        chk("rmw_valid", instr_valid, 0);
        @(negedge clk);
        reset = 1'b0; mem_ack = 1'b0; start = 1'b0;
        chk("rmw_req2", mem_req, 0);
        @(negedge clk);
        chk("rmw_idle_addr", instr_addr, 0);
        chk("rmw_idle_req", mem_req, 0);
        chk("rmw_idle_valid", instr_valid, 0);
        chk("rmw_idle_opcode", opcode, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
